spi_transfer_arbiter: RTL and testbench

- Shares one SPI master channel between N_REQ independent requesters.
- Arbitrates round-robin and latches the winner's word, then drives the SPI direct-write strobe.
- Waits for the SPI receive strobe and routes the received word back to the granted requester only.
- Sits between control-side producers (e.g. per-channel DAC/ADC sequencers) and the SPI master's SPI_write_data/SPI_write_valid/data_valid/data_out ports.

---
 rtl/spi_transfer_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_spi_transfer_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_transfer_arbiter
// Purpose  : Shares one SPI master channel between N_REQ requesters. Picks a
//            winner round-robin, issues its word to the SPI master with a
//            one-cycle write strobe, and returns the received word to that
//            requester only. Only one transfer is outstanding at any time.
// Ports    : clock, reset (async, active-low)
//            req_valid/req_data/req_ready    - requester side (packed words)
//            resp_valid/resp_data/resp_error - response side (one-hot valid)
//            spi_write_data/spi_write_valid  - to SPI master
//            spi_data_valid/spi_data_in      - from SPI master
//            busy, grant_id                  - status
// Options  : `define SPI_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT_CYCLES and
//            reports an expired transfer with resp_error=1, resp_data=0.
// Revision : 1.0 - initial release
// ============================================================================
module spi_transfer_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_data,
  output logic                        resp_error,
  output logic [DATA_WIDTH-1:0]       spi_write_data,
  output logic                        spi_write_valid,
  input  logic                        spi_data_valid,
  input  logic [DATA_WIDTH-1:0]       spi_data_in,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id
);

  localparam int c_ID_W  = $clog2(N_REQ);
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(N_REQ - 1);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_ISSUE   = 3'd1;
  localparam logic [2:0] c_ST_WAIT    = 3'd2;
  localparam logic [2:0] c_ST_RESPOND = 3'd3;
  localparam logic [2:0] c_ST_GAP     = 3'd4;

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_param
    $error("spi_transfer_arbiter: illegal parameter combination");
  end

  logic [2:0]            r_state;
  logic [c_ID_W-1:0]     r_rr_ptr;
  logic [c_ID_W-1:0]     r_gid;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [c_GAP_W-1:0]    r_gap_cnt;

  logic                  w_any;
  logic [c_ID_W-1:0]     w_pick;
  logic [c_ID_W:0]       w_sum;
  logic [DATA_WIDTH-1:0] w_words [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search. Walking the offsets from the far end back to zero
  // lets the nearest requester to rr_ptr overwrite any farther candidate.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (c_ID_W+1)'(k);
      if (w_sum >= (c_ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (c_ID_W+1)'(N_REQ);
      end
      if (req_valid[w_sum[c_ID_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[c_ID_W-1:0];
      end
    end
  end

  // The grant is combinational from req_valid, so it is also qualified by
  // reset to keep req_ready low while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset && (r_state == c_ST_IDLE) && w_any) begin
      req_ready[w_pick] = 1'b1;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (r_state == c_ST_RESPOND) begin
      resp_valid[r_gid] = 1'b1;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_resp_err;
  logic              w_timeout;

  // Cleared while issuing so it reads zero on the first WAIT cycle; it then
  // counts one per WAIT cycle and the transfer expires when it hits the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state == c_ST_ISSUE) begin
      r_to_cnt <= '0;
    end else if ((r_state == c_ST_WAIT) && (r_to_cnt != c_TO_LIMIT)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout  = (r_state == c_ST_WAIT) && (r_to_cnt == c_TO_LIMIT);
  assign resp_error = r_resp_err;
`else
  assign resp_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_IDLE;
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_word      <= '0;
      r_resp_data <= '0;
      r_gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_resp_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_any) begin
            r_word  <= w_words[w_pick];
            r_gid   <= w_pick;
            r_state <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          r_state <= c_ST_WAIT;
        end
        c_ST_WAIT: begin
          // A strobe on the expiry cycle is taken as a normal response.
          if (spi_data_valid) begin
            r_resp_data <= spi_data_in;
`ifdef SPI_ARB_TIMEOUT_EN
            r_resp_err  <= 1'b0;
`endif
            r_state     <= c_ST_RESPOND;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
            r_state     <= c_ST_RESPOND;
          end
`endif
        end
        c_ST_RESPOND: begin
          r_rr_ptr  <= (r_gid == c_ID_LAST) ? '0 : r_gid + 1'b1;
          r_gap_cnt <= '0;
          r_state   <= (GAP_CYCLES == 0) ? c_ST_IDLE : c_ST_GAP;
        end
        c_ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = (r_state != c_ST_IDLE);
  assign spi_write_valid = (r_state == c_ST_ISSUE);
  assign spi_write_data  = r_word;
  assign resp_data       = r_resp_data;
  assign grant_id        = r_gid;

endmodule
`default_nettype wire

// File: tb/tb_spi_transfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_transfer_arbiter
// Purpose  : Directed bench for spi_transfer_arbiter (4 requesters, 32-bit
//            words, 2 gap cycles, 16-cycle timeout when SPI_ARB_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_transfer_arbiter;

  localparam int c_N  = 4;
  localparam int c_DW = 32;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int c_D1 = 10;
`else
  localparam int c_D1 = 29;
`endif

  logic                   clock;
  logic                   reset;
  logic [c_N-1:0]         req_valid;
  logic [c_N*c_DW-1:0]    req_data;
  logic [c_N-1:0]         req_ready;
  logic [c_N-1:0]         resp_valid;
  logic [c_DW-1:0]        resp_data;
  logic                   resp_error;
  logic [c_DW-1:0]        spi_write_data;
  logic                   spi_write_valid;
  logic                   spi_data_valid;
  logic [c_DW-1:0]        spi_data_in;
  logic                   busy;
  logic [1:0]             grant_id;

  spi_transfer_arbiter #(
    .N_REQ(c_N), .DATA_WIDTH(c_DW), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .spi_write_data(spi_write_data), .spi_write_valid(spi_write_valid),
    .spi_data_valid(spi_data_valid), .spi_data_in(spi_data_in),
    .busy(busy), .grant_id(grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] base;
    logic [31:0] rword;
    int          dly;
    int          exp_g;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [6];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [3:0] mask, input logic [31:0] base);
    req_valid = mask;
    for (int i = 0; i < c_N; i++) req_data[i*c_DW +: c_DW] = base + 32'(i);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},  32'(req_ready), 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_resp_data"},  resp_data, 0);
    check({tag, "_resp_error"}, 32'(resp_error), 0);
    check({tag, "_wr_data"},    spi_write_data, 0);
    check({tag, "_wr_valid"},   32'(spi_write_valid), 0);
    check({tag, "_grant_id"},   32'(grant_id), 0);
    check({tag, "_busy"},       32'(busy), 0);
  endtask

  // One full transfer; ends two time units into the first GAP cycle.
  task automatic do_xfer(input vec_t v, input bit hold, output int waited);
    set_req(v.mask, v.base);
    #1;
    waited = 0;
    while (req_ready == 0 && waited < 20) begin
      tick(); #1; waited++;
    end
    check("grant", 32'(req_ready), 32'(1 << v.exp_g));
    tick();
    if (!hold) req_valid = '0;
    #1;
    check("wr_valid", 32'(spi_write_valid), 1);
    check("wr_data", spi_write_data, v.exp_wd);
    check("grant_id", 32'(grant_id), 32'(v.exp_g));
    check("busy_issue", 32'(busy), 1);
    tick(); #1;
    check("wr_once", 32'(spi_write_valid), 0);
    repeat (v.dly) tick();
    spi_data_valid = 1'b1;
    spi_data_in    = v.rword;
    tick();
    spi_data_valid = 1'b0;
    spi_data_in    = 32'h5A5A_5A5A;
    #1;
    check("resp_valid", 32'(resp_valid), 32'(1 << v.exp_g));
    check("resp_data", resp_data, v.rword);
    check("resp_error", 32'(resp_error), 0);
    tick(); #1;
    check("resp_once", 32'(resp_valid), 0);
    check("resp_hold", resp_data, v.rword);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   w;
    int   n;

    vecs[0] = '{mask: 4'b0100, base: 32'h0000_01A3, rword: 32'h0000_0ABC, dly: c_D1, exp_g: 2, exp_wd: 32'h0000_01A5};
    vecs[1] = '{mask: 4'b0011, base: 32'h1111_0000, rword: 32'h2222_0000, dly: 3,    exp_g: 0, exp_wd: 32'h1111_0000};
    vecs[2] = '{mask: 4'b1111, base: 32'hA000_0000, rword: 32'h0BAD_F00D, dly: 1,    exp_g: 1, exp_wd: 32'hA000_0001};
    vecs[3] = '{mask: 4'b1001, base: 32'h5555_AAA0, rword: 32'hFFFF_FFFF, dly: 5,    exp_g: 3, exp_wd: 32'h5555_AAA3};
    vecs[4] = '{mask: 4'b1000, base: 32'h0000_0010, rword: 32'h1234_5678, dly: 2,    exp_g: 3, exp_wd: 32'h0000_0013};
    vecs[5] = '{mask: 4'b0001, base: 32'hDEAD_BEE0, rword: 32'h0000_0000, dly: 7,    exp_g: 0, exp_wd: 32'hDEAD_BEE0};

    reset          = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    spi_data_valid = 1'b0;
    spi_data_in    = '0;
    #3;
    check_zero("rst");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Table of independent transfers exercising the rotation pointer.
    for (int i = 0; i < 6; i++) begin
      do_xfer(vecs[i], 1'b0, w);
    end

    // Spurious strobes in GAP and IDLE are ignored.
    spi_data_valid = 1'b1;
    spi_data_in    = 32'h0000_EEEE;
    tick();
    spi_data_valid = 1'b0;
    #1;
    check("spur_gap_resp", 32'(resp_valid), 0);
    check("spur_gap_busy", 32'(busy), 1);
    tick(); #1;
    check("spur_idle_busy", 32'(busy), 0);
    check("spur_gap_data", resp_data, 32'h0000_0000);
    spi_data_valid = 1'b1;
    tick();
    spi_data_valid = 1'b0;
    #1;
    check("spur_idle_resp", 32'(resp_valid), 0);
    check("spur_idle_busy2", 32'(busy), 0);
    tick(); #1;
    check("spur_idle_resp2", 32'(resp_valid), 0);
    check("spur_idle_data", resp_data, 32'h0000_0000);

    // All four requesting continuously from reset.
    reset = 1'b0;
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      v = '{mask: 4'b1111, base: 32'h0000_0100 * 32'(k + 1), rword: 32'h50 + 32'(k),
            dly: 2, exp_g: k % 4, exp_wd: 32'h0000_0100 * 32'(k + 1) + 32'(k % 4)};
      do_xfer(v, 1'b1, w);
      if (k > 0) check("gap_cycles", 32'(w), 2);
    end

    // Reset in WAIT: pointer is at 2, so mask 0010 grants requester 1.
    set_req(4'b0010, 32'h0000_7770);
    #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      tick(); #1; n++;
    end
    check("rw_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick(); #1;
    check("rw_busy_wait", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("rw");
    @(negedge clock);
    reset = 1'b1;
    tick();
    spi_data_valid = 1'b1;
    spi_data_in    = 32'h0000_0077;
    tick();
    spi_data_valid = 1'b0;
    #1;
    check("rw_late_resp", 32'(resp_valid), 0);
    check("rw_late_busy", 32'(busy), 0);
    tick(); #1;
    check("rw_late_resp2", 32'(resp_valid), 0);
    v = '{mask: 4'b1111, base: 32'h0000_0A00, rword: 32'h0000_0B0B, dly: 4, exp_g: 0, exp_wd: 32'h0000_0A00};
    do_xfer(v, 1'b0, w);

`ifdef SPI_ARB_TIMEOUT_EN
    // Pointer is at 1; mask 0100 grants requester 2, which is left unanswered.
    set_req(4'b0100, 32'h0000_0C00);
    #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      tick(); #1; n++;
    end
    check("to_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick(); #1;
    n = 0;
    while (resp_valid == 0 && n < 40) begin
      tick(); #1; n++;
    end
    check("to_latency", 32'(n), 17);
    check("to_resp_valid", 32'(resp_valid), 32'b0100);
    check("to_resp_error", 32'(resp_error), 1);
    check("to_resp_data", resp_data, 0);
    // Next in rotation is 3; its strobe lands exactly on the expiry cycle.
    v = '{mask: 4'b1111, base: 32'h0000_0D00, rword: 32'hCAFE_0001, dly: 16, exp_g: 3, exp_wd: 32'h0000_0D03};
    do_xfer(v, 1'b0, w);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
